// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared types and widths for the motor-control datapath (PID controller and
// H-bridge PWM driver).
//   DUTY_W / CNT_W / DT_W : default widths of duty, period counter, dead time
//   drive_state_t         : H-bridge drive FSM states
//   dir_t                 : latched drive direction requested by the duty word
//   dir_to_state()        : maps a requested direction onto its drive state
// -----------------------------------------------------------------------------
package motor_pkg;

  localparam int DUTY_W = 24;
  localparam int CNT_W  = 16;
  localparam int DT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } drive_state_t;

  typedef enum logic [1:0] {
    DIR_COAST = 2'd0,
    DIR_FWD   = 2'd1,
    DIR_REV   = 2'd2
  } dir_t;

  function automatic drive_state_t dir_to_state(input dir_t dir);
    case (dir)
      DIR_FWD: return ST_FWD;
      DIR_REV: return ST_REV;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
// Free-running PWM period counter for one H-bridge channel.
//   CLK            : system clock
//   reset          : asynchronous, active-high reset
//   i_period       : PWM period in CLK cycles; values below 2 hold the counter
//   o_cnt          : current count, runs 0 .. i_period-1
//   o_wrap         : high in the last cycle of a period (boundary latch point)
//   o_period_ok    : i_period is usable (>= 2)
//   o_period_start : registered pulse, high in the cycle after o_cnt == 0
// -----------------------------------------------------------------------------
module pwm_period_counter #(
  parameter int CNT_W = motor_pkg::CNT_W
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_period,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_period_ok,
  output logic             o_period_start
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_period_start;
  logic             w_period_ok;
  logic             w_wrap;

  assign w_period_ok = (i_period >= CNT_W'(2));

  // Compare with >= so that shrinking the period below the current count
  // wraps on the next cycle instead of running all the way round.
  assign w_wrap = w_period_ok && (r_cnt >= (i_period - CNT_W'(1)));

  // NOTE: clocked blocks use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else if (!w_period_ok) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
      r_period_start <= (r_cnt == '0);
    end
  end

  assign o_cnt          = r_cnt;
  assign o_wrap         = w_wrap;
  assign o_period_ok    = w_period_ok;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_hbridge_driver.sv
// -----------------------------------------------------------------------------
// pwm_hbridge_driver
// Converts the PID controller's signed duty word into direction pins and a
// PWM gate for one H-bridge channel. The duty word is sampled only at period
// boundaries; forward/reverse reversals pass through a dead-time state so the
// two bridge legs are never enabled together.
//   CLK          : system clock
//   reset        : asynchronous, active-high reset
//   enable       : synchronous run enable, low forces coast
//   duty         : signed duty command (two's complement)
//   deadband     : signed, only its magnitude is used; |duty| <= it coasts
//   period       : PWM period in CLK cycles (< 2 holds everything off)
//   deadtime     : reversal dead time in CLK cycles
//   in_a / in_b  : forward / reverse leg enables (registered)
//   pwm          : PWM gate (registered)
//   period_start : one-cycle pulse in the cycle after the counter is 0
//   saturated    : latched magnitude was clamped to the period
// -----------------------------------------------------------------------------
module pwm_hbridge_driver #(
  parameter int DUTY_W = motor_pkg::DUTY_W,
  parameter int CNT_W  = motor_pkg::CNT_W,
  parameter int DT_W   = motor_pkg::DT_W
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DUTY_W-1:0] duty,
  input  logic signed [DUTY_W-1:0] deadband,
  input  logic        [CNT_W-1:0]  period,
  input  logic        [DT_W-1:0]   deadtime,
  output logic                     in_a,
  output logic                     in_b,
  output logic                     pwm,
  output logic                     period_start,
  output logic                     saturated
);

  import motor_pkg::*;

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cnt;
  logic             w_wrap;
  logic             w_period_ok;
  logic             w_period_start;

  pwm_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .CLK            (CLK),
    .reset          (reset),
    .i_period       (period),
    .o_cnt          (w_cnt),
    .o_wrap         (w_wrap),
    .o_period_ok    (w_period_ok),
    .o_period_start (w_period_start)
  );

  // Drive is allowed only while enabled and with a usable period.
  logic w_drive_ok;
  assign w_drive_ok = enable && w_period_ok;

  // ---------------------------------------------------------------------------
  // Sign-magnitude decode of the duty word
  // ---------------------------------------------------------------------------
  logic [DUTY_W-1:0] w_duty_u;
  logic [DUTY_W-1:0] w_db_u;
  logic [DUTY_W-1:0] w_duty_mag;
  logic [DUTY_W-1:0] w_db_mag;
  logic [DUTY_W-1:0] w_period_ext;
  logic              w_clamp;
  dir_t              w_dir_new;
  logic [CNT_W-1:0]  w_mag_new;
  logic              w_sat_new;

  assign w_duty_u     = duty;
  assign w_db_u       = deadband;
  assign w_period_ext = DUTY_W'(period);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_dir_new = DIR_COAST;
    w_mag_new = '0;
    w_sat_new = 1'b0;
    // Unsigned negate: the most negative duty maps to 2^(DUTY_W-1) exactly.
    w_duty_mag = w_duty_u[DUTY_W-1] ? (DUTY_W'(0) - w_duty_u) : w_duty_u;
    w_db_mag   = w_db_u[DUTY_W-1]   ? (DUTY_W'(0) - w_db_u)   : w_db_u;
    w_clamp    = (w_duty_mag > w_period_ext);
    if (w_duty_mag > w_db_mag) begin
      w_dir_new = w_duty_u[DUTY_W-1] ? DIR_REV : DIR_FWD;
      // Unclamped magnitude is <= period, so its low CNT_W bits hold it.
      w_mag_new = w_clamp ? period : w_duty_mag[CNT_W-1:0];
      w_sat_new = w_clamp;
    end
  end

  // ---------------------------------------------------------------------------
  // Boundary latch: target direction, active magnitude, saturation flag.
  // r_eval marks the cycle after a latch, where the FSM acts on the target.
  // ---------------------------------------------------------------------------
  dir_t             r_target;
  logic [CNT_W-1:0] r_mag_act;
  logic             r_saturated;
  logic             r_eval;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_target    <= DIR_COAST;
      r_mag_act   <= '0;
      r_saturated <= 1'b0;
      r_eval      <= 1'b0;
    end else begin
      r_eval <= w_wrap && enable;

      // While disabled the target is parked at coast so that re-enabling
      // cannot drive anything before a fresh boundary sample.
      if (!enable) begin
        r_target <= DIR_COAST;
      end else if (w_wrap) begin
        r_target <= w_dir_new;
      end

      if (enable && w_wrap) begin
        r_mag_act <= w_mag_new;
      end

      if (!w_period_ok) begin
        r_saturated <= 1'b0;
      end else if (enable && w_wrap) begin
        r_saturated <= w_sat_new;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Direction FSM
  // ---------------------------------------------------------------------------
  drive_state_t    r_state;
  drive_state_t    w_state_next;
  logic [DT_W-1:0] r_dt_cnt;
  logic [DT_W-1:0] w_dt_next;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dt_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_dt_cnt <= w_dt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dt_next    = r_dt_cnt;
    if (!w_drive_ok) begin
      w_state_next = ST_IDLE;
      w_dt_next    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Coast to drive needs no dead time.
          if (r_eval) begin
            w_state_next = dir_to_state(r_target);
          end
        end

        ST_FWD: begin
          if (r_eval) begin
            if (r_target == DIR_COAST) begin
              w_state_next = ST_IDLE;
            end else if (r_target == DIR_REV) begin
              if (deadtime == '0) begin
                w_state_next = ST_REV;
              end else begin
                w_state_next = ST_DEAD;
                w_dt_next    = deadtime;
              end
            end
          end
        end

        ST_REV: begin
          if (r_eval) begin
            if (r_target == DIR_COAST) begin
              w_state_next = ST_IDLE;
            end else if (r_target == DIR_FWD) begin
              if (deadtime == '0) begin
                w_state_next = ST_FWD;
              end else begin
                w_state_next = ST_DEAD;
                w_dt_next    = deadtime;
              end
            end
          end
        end

        ST_DEAD: begin
          // Boundaries seen here only refresh the target; the count is not
          // restarted. The state is left as the count reaches zero, giving
          // exactly 'deadtime' cycles in DEAD, and goes to whatever target
          // is latched at that moment.
          w_dt_next = r_dt_cnt - DT_W'(1);
          if (r_dt_cnt <= DT_W'(1)) begin
            w_state_next = dir_to_state(r_target);
            w_dt_next    = '0;
          end
        end

        default: begin
          w_state_next = ST_IDLE;
          w_dt_next    = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. Gating with w_drive_ok here (not only through the FSM)
  // makes a dropped enable or a bad period silence the bridge on the very
  // next cycle. in_a and in_b decode one state value, so they are exclusive.
  // ---------------------------------------------------------------------------
  logic r_in_a;
  logic r_in_b;
  logic r_pwm;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_in_a <= 1'b0;
      r_in_b <= 1'b0;
      r_pwm  <= 1'b0;
    end else begin
      r_in_a <= w_drive_ok && (r_state == ST_FWD);
      r_in_b <= w_drive_ok && (r_state == ST_REV);
      r_pwm  <= w_drive_ok && ((r_state == ST_FWD) || (r_state == ST_REV))
                && (w_cnt < r_mag_act);
    end
  end

  assign in_a         = r_in_a;
  assign in_b         = r_in_b;
  assign pwm          = r_pwm;
  assign period_start = w_period_start;
  assign saturated    = r_saturated;

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
`timescale 1ns/1ps
module tb_pwm_hbridge_driver;
  import motor_pkg::*;

  localparam int DW = 24;
  localparam int CW = 16;
  localparam int TW = 8;
  localparam int NV = 21;

  logic                 CLK      = 1'b0;
  logic                 reset    = 1'b1;
  logic                 enable   = 1'b0;
  logic signed [DW-1:0] duty     = '0;
  logic signed [DW-1:0] deadband = '0;
  logic        [CW-1:0] period   = 16'd100;
  logic        [TW-1:0] deadtime = 8'd10;
  logic                 in_a;
  logic                 in_b;
  logic                 pwm;
  logic                 period_start;
  logic                 saturated;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  pwm_hbridge_driver #(
    .DUTY_W (DW),
    .CNT_W  (CW),
    .DT_W   (TW)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .enable       (enable),
    .duty         (duty),
    .deadband     (deadband),
    .period       (period),
    .deadtime     (deadtime),
    .in_a         (in_a),
    .in_b         (in_b),
    .pwm          (pwm),
    .period_start (period_start),
    .saturated    (saturated)
  );

  always #5 CLK = ~CLK;

  // Both bridge legs must never be enabled in the same cycle.
  always @(negedge CLK) begin
    if (in_a && in_b) overlap++;
  end

  typedef struct {
    logic                 en;
    logic signed [DW-1:0] duty;
    logic signed [DW-1:0] db;
    logic        [CW-1:0] period;
    logic        [TW-1:0] dt;
    int                   exp_a;
    int                   exp_b;
    int                   exp_pwm;
    int                   exp_sat;
    int                   exp_ps;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic en, input int d, input int db,
                              input int per, input int dt, input int a,
                              input int b, input int p, input int s,
                              input int ps);
    vec_t v;
    v.en      = en;
    v.duty    = d[DW-1:0];
    v.db      = db[DW-1:0];
    v.period  = per[CW-1:0];
    v.dt      = dt[TW-1:0];
    v.exp_a   = a;
    v.exp_b   = b;
    v.exp_pwm = p;
    v.exp_sat = s;
    v.exp_ps  = ps;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin : main
    int n;
    int c1;
    int c2;
    int gap;
    int gap_drive;

    //               en   duty      db        per  dt  a  b  pwm sat ps
    vecs[0]  = mk(1'b1,       50,        5, 100, 10, 1, 0,  50, 0, 1);
    vecs[1]  = mk(1'b1,        3,        5, 100, 10, 0, 0,   0, 0, 1);
    vecs[2]  = mk(1'b1,       -3,        5, 100, 10, 0, 0,   0, 0, 1);
    vecs[3]  = mk(1'b1,       40,        5, 100, 10, 1, 0,  40, 0, 1);
    vecs[4]  = mk(1'b1,      -40,        5, 100, 10, 0, 1,  40, 0, 1);
    vecs[5]  = mk(1'b1,      200,        5, 100, 10, 1, 0, 100, 1, 1);
    vecs[6]  = mk(1'b1, -8388608,        5, 100, 10, 0, 1, 100, 1, 1);
    vecs[7]  = mk(1'b1,        5,        5, 100, 10, 0, 0,   0, 0, 1);
    vecs[8]  = mk(1'b1,        6,        5, 100, 10, 1, 0,   6, 0, 1);
    vecs[9]  = mk(1'b1,       -8,      -10, 100, 10, 0, 0,   0, 0, 1);
    vecs[10] = mk(1'b1,      -11,      -10, 100, 10, 0, 1,  11, 0, 1);
    vecs[11] = mk(1'b1,      100,        5, 100, 10, 1, 0, 100, 0, 1);
    vecs[12] = mk(1'b1,      101,        5, 100, 10, 1, 0, 100, 1, 1);
    vecs[13] = mk(1'b1,        7,        5,  20, 10, 1, 0,   7, 0, 1);
    vecs[14] = mk(1'b1,        0,        0,  20, 10, 0, 0,   0, 0, 1);
    vecs[15] = mk(1'b0,       50,        5, 100, 10, 0, 0,   0, 0, 1);
    vecs[16] = mk(1'b1,       50,        5,   1, 10, 0, 0,   0, 0, 0);
    vecs[17] = mk(1'b1,       30,        5, 100,  0, 1, 0,  30, 0, 1);
    vecs[18] = mk(1'b1,      -30,        5, 100,  0, 0, 1,  30, 0, 1);
    vecs[19] = mk(1'b1, -8388608,  8388607, 100,  0, 0, 1, 100, 1, 1);
    vecs[20] = mk(1'b1, -8388608, -8388608, 100,  0, 0, 0,   0, 0, 1);

    // Reset state and first-boundary latency.
    enable   = 1'b1;
    duty     = 24'sd50;
    deadband = 24'sd5;
    period   = 16'd100;
    deadtime = 8'd10;
    step(3);
    check("reset_outputs", int'({in_a, in_b, pwm, period_start, saturated}), 0);
    check("reset_cnt", int'(dut.w_cnt), 0);
    reset = 1'b0;
    step(1);
    check("ps_first", int'(period_start), 1);
    step(1);
    check("ps_clear", int'(period_start), 0);
    step(99);
    check("latency_a_before", int'(in_a), 0);
    check("latency_ps_wrap", int'(period_start), 1);
    step(1);
    check("latency_a_after", int'(in_a), 1);
    check("latency_pwm_first", int'(pwm), 1);

    // Steady-state vectors, each measured over one full period window.
    for (int i = 0; i < NV; i++) begin : vec_loop
      int win;
      int ca;
      int cb;
      int cp;
      int cs;
      int cps;
      enable   = vecs[i].en;
      duty     = vecs[i].duty;
      deadband = vecs[i].db;
      period   = vecs[i].period;
      deadtime = vecs[i].dt;
      win = (vecs[i].period < 16'd2) ? 50 : int'(vecs[i].period);
      step(3 * win + 20);
      ca = 0; cb = 0; cp = 0; cs = 0; cps = 0;
      for (int k = 0; k < win; k++) begin
        ca  += int'(in_a);
        cb  += int'(in_b);
        cp  += int'(pwm);
        cs  += int'(saturated);
        cps += int'(period_start);
        step(1);
      end
      check($sformatf("v%0d in_a_cycles", i), ca, vecs[i].exp_a * win);
      check($sformatf("v%0d in_b_cycles", i), cb, vecs[i].exp_b * win);
      check($sformatf("v%0d pwm_cycles", i), cp, vecs[i].exp_pwm);
      check($sformatf("v%0d sat_cycles", i), cs, vecs[i].exp_sat * win);
      check($sformatf("v%0d ps_pulses", i), cps, vecs[i].exp_ps);
    end

    // Reversal FWD +40 -> REV -40 with 10 cycles of dead time.
    enable   = 1'b1;
    deadband = 24'sd5;
    period   = 16'd100;
    deadtime = 8'd10;
    duty     = 24'sd40;
    step(300);
    check("rev_pre_fwd", int'(in_a), 1);
    duty = -24'sd40;
    n = 0;
    while (in_a !== 1'b0 && n < 300) begin
      step(1);
      n++;
    end
    check("rev_a_fall_in_time", int'(n < 300), 1);
    gap = 0;
    gap_drive = 0;
    while (in_b !== 1'b1 && gap < 300) begin
      gap_drive += int'(in_a) + int'(pwm);
      step(1);
      gap++;
    end
    check("rev_dead_cycles", gap, 10);
    check("rev_dead_quiet", gap_drive, 0);

    // Mid-period duty change: the new width applies only from the next period.
    duty = 24'sd20;
    step(300);
    n = 0;
    while (period_start !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    check("mid_sync_in_time", int'(n < 300), 1);
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == 30) duty = 24'sd70;
      if (k < 100) c1 += int'(pwm);
      else         c2 += int'(pwm);
      step(1);
    end
    check("mid_width_old", c1, 20);
    check("mid_width_new", c2, 70);

    // Enable dropped while driving, then re-enabled mid-period.
    n = 0;
    while (pwm !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    check("en_sync_in_time", int'(n < 300), 1);
    enable = 1'b0;
    step(1);
    check("en_drop_outputs", int'({in_a, in_b, pwm}), 0);
    step(150);
    n = 0;
    while (period_start !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    check("reen_sync_in_time", int'(n < 300), 1);
    step(40);
    enable = 1'b1;
    c1 = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      c1 += int'(in_a) + int'(in_b) + int'(pwm);
    end
    check("reen_quiet_until_boundary", c1, 0);
    step(1);
    check("reen_resume_a", int'(in_a), 1);

    // Asynchronous reset while driving forward.
    step(5);
    check("rst_pre_fwd", int'(in_a), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_fwd_outputs", int'({in_a, in_b, pwm, period_start, saturated}), 0);
    check("rst_fwd_cnt", int'(dut.w_cnt), 0);
    @(negedge CLK);
    reset = 1'b0;

    // Asynchronous reset in the middle of a long dead time.
    duty     = 24'sd40;
    deadtime = 8'd50;
    step(300);
    duty = -24'sd40;
    n = 0;
    while (in_a !== 1'b0 && n < 300) begin
      step(1);
      n++;
    end
    check("dead_a_fall_in_time", int'(n < 300), 1);
    step(5);
    check("dead_state", int'(dut.r_state), int'(ST_DEAD));
    #2 reset = 1'b1;
    #1;
    check("rst_dead_outputs", int'({in_a, in_b, pwm, period_start, saturated}), 0);
    check("rst_dead_cnt", int'(dut.w_cnt), 0);
    check("rst_dead_state", int'(dut.r_state), int'(ST_IDLE));
    @(negedge CLK);
    reset = 1'b0;
    step(1);
    check("cnt_restart", int'(dut.w_cnt), 1);

    check("legs_never_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
